alu_seq_ctrl: RTL and testbench
===============================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, max WAIT-state cycles before the watchdog fires (used only with ALU_SEQ_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  begin a sequence; sampled only in IDLE.
REQ-005 SHALL have port len  input  3  number of operations minus 1, latched on accepted start.
REQ-006 SHALL have port abort  input  1  synchronous cancel of the running sequence.
REQ-007 SHALL have port alu_done  input  1  ALU completion strobe for the current operation.
REQ-008 SHALL have port addr  output  3  operand/op-table address, Gray-coded.
REQ-009 SHALL have port alu_start  output  1  one-cycle ALU launch strobe.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port seq_done  output  1  one-cycle pulse when the final operation completes.
REQ-012 SHALL have port err  output  1  sticky watchdog error flag.

Function
REQ-013 SHALL implement states IDLE, ISSUE, WAIT, DONE (plus ERR with ALU_SEQ_TIMEOUT_EN).
REQ-014 SHALL, in IDLE with start=1, latch len into ops_left, clear err, and enter ISSUE next cycle.
REQ-015 SHALL assert alu_start only in ISSUE, exactly one cycle per operation, then enter WAIT.
REQ-016 SHALL ignore alu_done outside WAIT, including alu_done coincident with alu_start.
REQ-017 SHALL, in WAIT with alu_done=1 and ops_left!=0, decrement ops_left, advance addr, and enter ISSUE.
REQ-018 SHALL, in WAIT with alu_done=1 and ops_left==0, enter DONE without advancing addr.
REQ-019 SHALL advance addr in Gray order 000,001,011,010,110,111,101,100, wrapping 100->000.
REQ-020 SHALL hold addr constant throughout ISSUE and WAIT of an operation.
REQ-021 SHALL, in DONE, pulse seq_done for one cycle, clear addr to 000, and return to IDLE.
REQ-022 SHALL ignore start whenever busy=1.
REQ-023 SHALL, on abort=1 in any non-IDLE state, enter IDLE next cycle with addr=000, no seq_done, no alu_start; abort takes priority over alu_done and the watchdog.
REQ-024 SHALL sequence exactly len+1 operations; len=7 covers all eight addresses once.

Reset
REQ-025 SHALL, while reset=0, force state=IDLE, addr=000, ops_left=0, watchdog count=0, alu_start=0, busy=0, seq_done=0, err=0 immediately, independent of clk.
REQ-026 SHALL, on reset mid-sequence, discard the sequence; the first start after release begins at addr 000.

Configuration
REQ-027 SHALL compile the watchdog only when ALU_SEQ_TIMEOUT_EN is defined.
REQ-028 SHALL, with ALU_SEQ_TIMEOUT_EN, count WAIT cycles (reset on ISSUE) and, when TIMEOUT cycles elapse without alu_done, enter ERR, set err=1, and go to IDLE next cycle with addr=000 and no seq_done.
REQ-029 SHALL, without ALU_SEQ_TIMEOUT_EN, wait in WAIT indefinitely and tie err to 0.

Structure
REQ-030 SHALL place the state enum, the 3-bit Gray next-address function, and the TIMEOUT default in package alu_seq_pkg.
REQ-031 SHALL implement the address register as sub-module gray3_counter (inputs clk, reset, adv, clr; output 3-bit count).

Verification
REQ-032 SHALL test: reset=0 mid-WAIT at addr 011 -> all outputs 0 and addr 000 within the same cycle, no clock needed.
REQ-033 SHALL test: start with len=7, alu_done 2 cycles after each alu_start -> addr 000,001,011,010,110,111,101,100, 8 alu_start pulses, one seq_done, addr 000 afterward.
REQ-034 SHALL test: start with len=0, alu_done asserted in the ISSUE cycle and again in WAIT -> only the WAIT alu_done counts; one alu_start, seq_done one cycle later.
REQ-035 SHALL test: len=3, abort and alu_done together during the second WAIT -> IDLE next cycle, addr 000, no seq_done; start pulsed while busy was ignored.
REQ-036 SHALL test (ALU_SEQ_TIMEOUT_EN, TIMEOUT=4): alu_done never asserted -> err=1 after 4 WAIT cycles, busy=0 next cycle; next start clears err.
REQ-037 SHALL test (no ALU_SEQ_TIMEOUT_EN): alu_done held low 100 cycles -> stays in WAIT, busy=1, err=0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types for alu_seq_ctrl: sequencer state encoding, Gray address step and watchdog default.
// The optional watchdog is enabled by defining ALU_SEQ_TIMEOUT_EN.
package alu_seq_pkg;

  localparam int unsigned ADDR_W          = 3;
  localparam int unsigned LEN_W           = 3;
  localparam int unsigned TIMEOUT_DEFAULT = 15;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  // Next 3-bit Gray code: decode to binary, increment, re-encode (wraps 100 -> 000).
  function automatic logic [ADDR_W-1:0] gray_next(input logic [ADDR_W-1:0] g);
    logic [ADDR_W-1:0] b;
    b[2] = g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    b    = b + ADDR_W'(1);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/alu_seq_gray3_counter.sv
// gray3_counter: operand/op-table address register stepping in 3-bit Gray order.
module gray3_counter
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              adv,
  input  logic              clr,
  output logic [ADDR_W-1:0] count
);

  // Clear wins over advance so an abort or sequence end always parks at 000.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (adv) begin
      count <= gray_next(count);
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: issues len+1 ALU operations over Gray-coded addresses, one launch per op.
// Define ALU_SEQ_TIMEOUT_EN to build the WAIT-state watchdog (ERR state, sticky err).
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  input  logic              alu_done,
  output logic [ADDR_W-1:0] addr,
  output logic              alu_start,
  output logic              busy,
  output logic              seq_done,
  output logic              err
);

  state_t           state;
  state_t           state_nx;
  logic [LEN_W-1:0] ops_left;
  logic [LEN_W-1:0] ops_left_nx;
  logic             adv;
  logic             clr;
  logic             wd_fire;

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [WD_W-1:0] wd_cnt;

  // Fires on the TIMEOUT-th consecutive WAIT cycle without a completion.
  assign wd_fire = (state == WAIT) && !alu_done && (wd_cnt == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
    end else if (state == ISSUE) begin
      wd_cnt <= '0;
    end else if ((state == WAIT) && !alu_done && !wd_fire) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (state_nx == ERR) begin
      err <= 1'b1;
    end else if ((state == IDLE) && start) begin
      err <= 1'b0;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = 1'(TIMEOUT % 2);
  assign wd_fire        = 1'b0;
  assign err            = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ops_left  <= '0;
      alu_start <= 1'b0;
      busy      <= 1'b0;
      seq_done  <= 1'b0;
    end else begin
      state     <= state_nx;
      ops_left  <= ops_left_nx;
      alu_start <= (state_nx == ISSUE);
      busy      <= (state_nx != IDLE);
      seq_done  <= (state_nx == DONE);
    end
  end

  // Next state; abort overrides completion and watchdog in every busy state.
  always_comb begin
    state_nx    = state;
    ops_left_nx = ops_left;
    adv         = 1'b0;
    clr         = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          ops_left_nx = len;
          state_nx    = ISSUE;
        end
      end
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (alu_done) begin
          if (ops_left != '0) begin
            ops_left_nx = ops_left - LEN_W'(1);
            adv         = 1'b1;
            state_nx    = ISSUE;
          end else begin
            state_nx = DONE;
          end
        end else if (wd_fire) begin
          state_nx = ERR;
        end
      end
      DONE: begin
        clr      = 1'b1;
        state_nx = IDLE;
      end
      ERR: begin
        clr      = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        clr      = 1'b1;
        state_nx = IDLE;
      end
    endcase
    if (abort && (state != IDLE)) begin
      state_nx = IDLE;
      adv      = 1'b0;
      clr      = 1'b1;
    end
  end

  gray3_counter u_addr (
    .clk   (clk),
    .reset (reset),
    .adv   (adv),
    .clr   (clr),
    .count (addr)
  );

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: per-cycle comparison against an operation-level model plus directed scenarios.
module tb_alu_seq_ctrl;

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int unsigned TB_TO = 4;
`else
  localparam int unsigned TB_TO = 15;
`endif

  localparam int P_IDLE  = 0;
  localparam int P_ISSUE = 1;
  localparam int P_WAIT  = 2;
  localparam int P_FIN   = 3;
  localparam int P_ERR   = 4;

  logic       clk      = 1'b0;
  logic       reset    = 1'b0;
  logic       start    = 1'b0;
  logic       abort    = 1'b0;
  logic       alu_done = 1'b0;
  logic [2:0] len      = 3'd0;
  logic [2:0] addr;
  logic       alu_start;
  logic       busy;
  logic       seq_done;
  logic       err;

  int n_vec = 0;
  int n_mis = 0;

  // Model: which phase of which operation the sequence is in.
  int m_ph    = P_IDLE;
  int m_idx   = 0;
  int m_total = 1;
  int m_wcnt  = 0;
  bit m_err   = 1'b0;

  logic [2:0] gray_seq [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

  always #5 clk = ~clk;

  alu_seq_ctrl #(.TIMEOUT(TB_TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .abort     (abort),
    .alu_done  (alu_done),
    .addr      (addr),
    .alu_start (alu_start),
    .busy      (busy),
    .seq_done  (seq_done),
    .err       (err)
  );

  function automatic logic [2:0] gray_of(input int i);
    logic [2:0] b;
    b = 3'(i);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_step();
    if ((m_ph != P_IDLE) && abort) begin
      m_ph  = P_IDLE;
      m_idx = 0;
    end else begin
      case (m_ph)
        P_IDLE: if (start) begin
          m_total = int'(len) + 1;
          m_idx   = 0;
          m_err   = 1'b0;
          m_ph    = P_ISSUE;
        end
        P_ISSUE: begin
          m_ph   = P_WAIT;
          m_wcnt = 0;
        end
        P_WAIT: begin
          if (alu_done) begin
            if (m_idx + 1 < m_total) begin
              m_idx = m_idx + 1;
              m_ph  = P_ISSUE;
            end else begin
              m_ph = P_FIN;
            end
          end else begin
`ifdef ALU_SEQ_TIMEOUT_EN
            m_wcnt = m_wcnt + 1;
            if (m_wcnt == int'(TB_TO)) begin
              m_ph  = P_ERR;
              m_err = 1'b1;
            end
`endif
          end
        end
        default: begin
          m_ph  = P_IDLE;
          m_idx = 0;
        end
      endcase
    end
  endtask

  // Per-cycle compare of every output against the model.
  always @(posedge clk) begin
    if (!reset) begin
      m_ph   = P_IDLE;
      m_idx  = 0;
      m_wcnt = 0;
      m_err  = 1'b0;
    end else begin
      m_step();
    end
    #1;
    chk("addr",      8'(addr),      8'(gray_of(m_idx)));
    chk("alu_start", 8'(alu_start), 8'(m_ph == P_ISSUE));
    chk("busy",      8'(busy),      8'(m_ph != P_IDLE));
    chk("seq_done",  8'(seq_done),  8'(m_ph == P_FIN));
    chk("err",       8'(err),       8'(m_err));
  end

  task automatic tick(input logic s, input logic [2:0] l, input logic ab, input logic ad);
    @(negedge clk);
    start    = s;
    len      = l;
    abort    = ab;
    alu_done = ad;
  endtask

  task automatic run_len7();
    logic [2:0] seen [8];
    int ns;
    int nd;
    int cd;
    ns = 0;
    nd = 0;
    cd = 0;
    for (int k = 0; k < 8; k++) seen[k] = 3'b000;
    tick(1'b1, 3'd7, 1'b0, 1'b0);
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      start    = 1'b0;
      abort    = 1'b0;
      alu_done = 1'b0;
      if (alu_start) begin
        if (ns < 8) seen[ns] = addr;
        ns++;
        cd = 2;
      end else if (cd > 0) begin
        cd--;
        alu_done = (cd == 0);
      end
      if (seq_done) nd++;
    end
    chk("len7_starts", 8'(ns), 8'd8);
    chk("len7_dones",  8'(nd), 8'd1);
    for (int k = 0; k < 8; k++) chk("len7_addr_seq", 8'(seen[k]), 8'(gray_seq[k]));
    chk("len7_addr_after", 8'(addr), 8'd0);
    chk("len7_busy_after", 8'(busy), 8'd0);
  endtask

  initial begin
    #1;
    chk("rst_addr",      8'(addr),      8'd0);
    chk("rst_alu_start", 8'(alu_start), 8'd0);
    chk("rst_busy",      8'(busy),      8'd0);
    chk("rst_seq_done",  8'(seq_done),  8'd0);
    chk("rst_err",       8'(err),       8'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    run_len7();

    // len=0 with a completion strobe during the launch cycle as well as in WAIT.
    tick(1'b1, 3'd0, 1'b0, 1'b0);
    tick(1'b0, 3'd0, 1'b0, 1'b1);
    chk("l0_issue_start", 8'(alu_start), 8'd1);
    tick(1'b0, 3'd0, 1'b0, 1'b1);
    chk("l0_wait_busy", 8'(busy), 8'd1);
    chk("l0_wait_nodone", 8'(seq_done), 8'd0);
    tick(1'b0, 3'd0, 1'b0, 1'b0);
    chk("l0_done_pulse", 8'(seq_done), 8'd1);
    tick(1'b0, 3'd0, 1'b0, 1'b0);
    chk("l0_idle_busy", 8'(busy), 8'd0);
    chk("l0_idle_done", 8'(seq_done), 8'd0);

    // len=3, start pulsed while busy, then abort with alu_done in the second WAIT.
    tick(1'b1, 3'd3, 1'b0, 1'b0);
    tick(1'b1, 3'd5, 1'b0, 1'b0);
    chk("ab_issue0_addr", 8'(addr), 8'd0);
    tick(1'b0, 3'd0, 1'b0, 1'b1);
    tick(1'b1, 3'd0, 1'b0, 1'b0);
    chk("ab_issue1_addr", 8'(addr), 8'b001);
    chk("ab_issue1_start", 8'(alu_start), 8'd1);
    tick(1'b0, 3'd0, 1'b1, 1'b1);
    tick(1'b0, 3'd0, 1'b0, 1'b0);
    chk("ab_idle_busy", 8'(busy), 8'd0);
    chk("ab_idle_addr", 8'(addr), 8'd0);
    chk("ab_idle_done", 8'(seq_done), 8'd0);
    chk("ab_idle_start", 8'(alu_start), 8'd0);
    for (int i = 0; i < 3; i++) tick(1'b0, 3'd0, 1'b0, 1'b0);
    chk("ab_no_done", 8'(seq_done), 8'd0);

`ifdef ALU_SEQ_TIMEOUT_EN
    tick(1'b1, 3'd0, 1'b0, 1'b0);
    tick(1'b0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 3'd0, 1'b0, 1'b0);
    chk("wd_wait4_err", 8'(err), 8'd0);
    tick(1'b0, 3'd0, 1'b0, 1'b0);
    chk("wd_err_set", 8'(err), 8'd1);
    chk("wd_err_busy", 8'(busy), 8'd1);
    tick(1'b1, 3'd2, 1'b0, 1'b0);
    chk("wd_idle_busy", 8'(busy), 8'd0);
    chk("wd_idle_err", 8'(err), 8'd1);
    chk("wd_idle_addr", 8'(addr), 8'd0);
    tick(1'b0, 3'd0, 1'b1, 1'b0);
    chk("wd_err_cleared", 8'(err), 8'd0);
    tick(1'b0, 3'd0, 1'b0, 1'b0);
`else
    tick(1'b1, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) tick(1'b0, 3'd0, 1'b0, 1'b0);
    chk("hang_busy", 8'(busy), 8'd1);
    chk("hang_err", 8'(err), 8'd0);
    tick(1'b0, 3'd0, 1'b1, 1'b0);
    tick(1'b0, 3'd0, 1'b0, 1'b0);
    chk("hang_abort_busy", 8'(busy), 8'd0);
`endif

    for (int i = 0; i < 800; i++) begin
      tick(1'($urandom_range(0, 99) < 30), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 99) < 4), 1'($urandom_range(0, 99) < 45));
    end

    // Async reset in the third WAIT of a long sequence (address 011).
    tick(1'b0, 3'd0, 1'b1, 1'b0);
    tick(1'b0, 3'd0, 1'b0, 1'b0);
    tick(1'b1, 3'd7, 1'b0, 1'b0);
    tick(1'b0, 3'd0, 1'b0, 1'b0);
    tick(1'b0, 3'd0, 1'b0, 1'b1);
    tick(1'b0, 3'd0, 1'b0, 1'b0);
    tick(1'b0, 3'd0, 1'b0, 1'b1);
    tick(1'b0, 3'd0, 1'b0, 1'b0);
    tick(1'b0, 3'd0, 1'b0, 1'b0);
    chk("mid_addr", 8'(addr), 8'b011);
    chk("mid_busy", 8'(busy), 8'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_addr",      8'(addr),      8'd0);
    chk("arst_alu_start", 8'(alu_start), 8'd0);
    chk("arst_busy",      8'(busy),      8'd0);
    chk("arst_seq_done",  8'(seq_done),  8'd0);
    chk("arst_err",       8'(err),       8'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick(1'b1, 3'd5, 1'b0, 1'b0);
    tick(1'b0, 3'd0, 1'b0, 1'b0);
    chk("post_rst_addr", 8'(addr), 8'd0);
    chk("post_rst_start", 8'(alu_start), 8'd1);
    for (int i = 0; i < 4; i++) tick(1'b0, 3'd0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL sim_timeout: got no end of stimulus expected finish before %0t", $time);
    $fatal(1);
  end

endmodule
